// File: rtl/pipeline_stage_controller_pkg.sv
// ----------------------------------------------------------------------------
// RafiTypes
// Shared types and default parameter values for the pipeline stage
// controller and its watchdog.
//   stageState_e          : controller FSM state (RUN / FLUSH)
//   DEFAULT_FLUSH_CYCLES  : default total cycles a flush stays asserted
//   DEFAULT_STALL_TIMEOUT : default consecutive-stall cycles before the
//                           watchdog flag fires
// ----------------------------------------------------------------------------
package RafiTypes;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } stageState_e;

  localparam int DEFAULT_FLUSH_CYCLES  = 2;
  localparam int DEFAULT_STALL_TIMEOUT = 255;

endpackage

// File: rtl/pipeline_stage_controller_stall_watchdog.sv
// ----------------------------------------------------------------------------
// stall_watchdog
// Counts stall activity for the pipeline stage controller.
//   clk            : clock, all state on rising edge
//   rst            : asynchronous active-low reset
//   anyStall_i     : at least one stage is stalled this cycle
//   counterClear_i : synchronous clear of all counters and the sticky flag
//   stallTimeout_o : sticky flag, set once the run of consecutive stall
//                    cycles reaches STALL_TIMEOUT
//   stallCycles_o  : saturating total of cycles with any stall
// ----------------------------------------------------------------------------
module stall_watchdog
  import RafiTypes::*;
#(
  parameter int STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        anyStall_i,
  input  logic        counterClear_i,
  output logic        stallTimeout_o,
  output logic [31:0] stallCycles_o
);

  localparam logic [15:0] LIMIT = 16'(STALL_TIMEOUT);

  logic [15:0] runLen_q, runLen_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cycles_q, cycles_d;

  // Next-state for the run-length counter, the sticky flag and the total.
  // A clear beats a stall in the same cycle. Both counters saturate.
  always_comb begin
    runLen_d  = runLen_q;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    if (counterClear_i) begin
      runLen_d  = '0;
      timeout_d = 1'b0;
      cycles_d  = '0;
    end else if (anyStall_i) begin
      runLen_d = (runLen_q == LIMIT) ? runLen_q : runLen_q + 16'd1;
      cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
      if (runLen_d == LIMIT) begin
        timeout_d = 1'b1;
      end
    end else begin
      runLen_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      runLen_q  <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      runLen_q  <= runLen_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign stallTimeout_o = timeout_q;
  assign stallCycles_o  = cycles_q;

endmodule

// File: rtl/pipeline_stage_controller.sv
// ----------------------------------------------------------------------------
// pipeline_stage_controller
// Generates per-stage stall, flush and bubble controls for an in-order
// pipeline. Stage 0 is the youngest instruction, stage STAGE_COUNT-1 the
// oldest.
//   clk          : clock, all state on rising edge
//   rst          : asynchronous active-low reset
//   stallReq     : per-stage "cannot advance" request
//   flushReq     : per-stage redirect; bit k flushes every stage younger than k
//   counterClear : synchronous clear of stallCycles and stallTimeout
//   stall        : per-stage hold (stage keeps its contents)
//   flush        : per-stage invalidate
//   bubble       : insert a NOP into stage i (bit 0 always 0)
//   flushing     : FSM is holding a flush
//   stallTimeout : sticky watchdog flag
//   stallCycles  : saturating count of cycles with any stall
// ----------------------------------------------------------------------------
module pipeline_stage_controller
  import RafiTypes::*;
#(
  parameter int STAGE_COUNT   = 6,
  parameter int FLUSH_CYCLES  = DEFAULT_FLUSH_CYCLES,
  parameter int STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STAGE_COUNT-1:0] stallReq,
  input  logic [STAGE_COUNT-1:0] flushReq,
  input  logic                   counterClear,
  output logic [STAGE_COUNT-1:0] stall,
  output logic [STAGE_COUNT-1:0] flush,
  output logic [STAGE_COUNT-1:0] bubble,
  output logic                   flushing,
  output logic                   stallTimeout,
  output logic [31:0]            stallCycles
);

  // The request cycle itself counts as the first flush cycle, so the hold
  // counter covers the remaining FLUSH_CYCLES-1 cycles and reloads to -2.
  localparam logic [3:0] HOLD_RELOAD = 4'(FLUSH_CYCLES - 2);
  localparam bit         FLUSH_HOLDS = (FLUSH_CYCLES > 1);

  stageState_e            state_q;
  logic [STAGE_COUNT-1:0] heldMask_q;
  logic [3:0]             holdCount_q;

  logic [STAGE_COUNT-1:0] reqMask;
  logic [STAGE_COUNT-1:0] rawStall;
  logic                   flushAcc;
  logic                   stallAcc;

  // Walk from the oldest stage down: a flush request at stage k marks only
  // the strictly younger stages, a stall request at stage j freezes stage j
  // and everything younger.
  always_comb begin
    reqMask  = '0;
    rawStall = '0;
    flushAcc = 1'b0;
    stallAcc = 1'b0;
    for (int i = STAGE_COUNT - 1; i >= 0; i--) begin
      reqMask[i]  = flushAcc;
      flushAcc    = flushAcc | flushReq[i];
      stallAcc    = stallAcc | stallReq[i];
      rawStall[i] = stallAcc;
    end
  end

  assign flush = reqMask | heldMask_q;
  assign stall = rawStall & ~flush;

  // A bubble appears where a stalled younger stage sits behind an older
  // stage that is moving on and not being flushed.
  always_comb begin
    bubble = '0;
    for (int i = 1; i < STAGE_COUNT; i++) begin
      bubble[i] = stall[i-1] & ~stall[i] & ~flush[i];
    end
  end

  // Flush hold FSM. New requests during a hold merge into the held mask and
  // restart the hold window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      heldMask_q  <= '0;
      holdCount_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if ((reqMask != '0) && FLUSH_HOLDS) begin
            state_q     <= FLUSH;
            heldMask_q  <= reqMask;
            holdCount_q <= HOLD_RELOAD;
          end
        end
        FLUSH: begin
          if (reqMask != '0) begin
            heldMask_q  <= heldMask_q | reqMask;
            holdCount_q <= HOLD_RELOAD;
          end else if (holdCount_q == 4'd0) begin
            state_q    <= RUN;
            heldMask_q <= '0;
          end else begin
            holdCount_q <= holdCount_q - 4'd1;
          end
        end
        default: begin
          state_q    <= RUN;
          heldMask_q <= '0;
        end
      endcase
    end
  end

  assign flushing = (state_q == FLUSH);

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) watchdog (
    .clk           (clk),
    .rst           (rst),
    .anyStall_i    (|stall),
    .counterClear_i(counterClear),
    .stallTimeout_o(stallTimeout),
    .stallCycles_o (stallCycles)
  );

endmodule

// File: tb/tb_pipeline_stage_controller.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stage_controller
// Scoreboard bench: the driver computes each cycle's expected outputs from a
// behavioural model and queues them; a monitor on the falling edge pops and
// compares against the DUT.
// ----------------------------------------------------------------------------
module tb_pipeline_stage_controller;

  localparam int SC  = 6;
  localparam int FC  = 3;
  localparam int STO = 4;

  logic          clk;
  logic          rst;
  logic [SC-1:0] stallReq;
  logic [SC-1:0] flushReq;
  logic          counterClear;
  logic [SC-1:0] stall;
  logic [SC-1:0] flush;
  logic [SC-1:0] bubble;
  logic          flushing;
  logic          stallTimeout;
  logic [31:0]   stallCycles;

  typedef struct {
    string         tag;
    logic [SC-1:0] stall;
    logic [SC-1:0] flush;
    logic [SC-1:0] bubble;
    logic          flushing;
    logic          timeout;
    logic [31:0]   cycles;
  } expect_t;

  expect_t expQ[$];

  int checks   = 0;
  int failures = 0;

  // Model state: which stages are under a held flush, how many more cycles
  // that hold lasts, and the stall statistics.
  logic [SC-1:0] mHeld = '0;
  int            mLeft = 0;
  int            mRun  = 0;
  longint        mCyc  = 0;
  bit            mTo   = 1'b0;

  pipeline_stage_controller #(
    .STAGE_COUNT  (SC),
    .FLUSH_CYCLES (FC),
    .STALL_TIMEOUT(STO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallReq    (stallReq),
    .flushReq    (flushReq),
    .counterClear(counterClear),
    .stall       (stall),
    .flush       (flush),
    .bubble      (bubble),
    .flushing    (flushing),
    .stallTimeout(stallTimeout),
    .stallCycles (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, queue what the
  // outputs must be for this cycle, then advance the model past the next edge.
  task automatic applyStimulus(input logic [SC-1:0] sReq, input logic [SC-1:0] fReq,
                               input logic clr, input logic rstVal, input string tag);
    expect_t       e;
    logic [SC-1:0] reqM;
    logic [SC-1:0] raw;
    logic [SC-1:0] fl;
    logic [SC-1:0] st;
    logic [SC-1:0] bu;
    @(posedge clk);
    #1;
    stallReq     = sReq;
    flushReq     = fReq;
    counterClear = clr;
    rst          = rstVal;
    if (!rstVal) begin
      mHeld = '0; mLeft = 0; mRun = 0; mCyc = 0; mTo = 1'b0;
    end
    for (int i = 0; i < SC; i++) begin
      reqM[i] = ((fReq >> (i + 1)) != '0);
      raw[i]  = ((sReq >> i) != '0);
    end
    fl = reqM | mHeld;
    st = raw & ~fl;
    bu = '0;
    for (int i = 1; i < SC; i++) bu[i] = st[i-1] && !st[i] && !fl[i];
    e.tag      = tag;
    e.stall    = st;
    e.flush    = fl;
    e.bubble   = bu;
    e.flushing = (mLeft > 0);
    e.timeout  = mTo;
    e.cycles   = mCyc[31:0];
    expQ.push_back(e);
    if (rstVal) begin
      if (reqM != '0) begin
        mHeld = mHeld | reqM;
        mLeft = FC - 1;
      end else if (mLeft > 0) begin
        mLeft--;
      end
      if (mLeft == 0) mHeld = '0;
      if (clr) begin
        mRun = 0; mCyc = 0; mTo = 1'b0;
      end else if (st != '0) begin
        if (mRun < STO) mRun++;
        if (mCyc < 64'hFFFF_FFFF) mCyc++;
        if (mRun == STO) mTo = 1'b1;
      end else begin
        mRun = 0;
      end
    end
  endtask

  // Monitor: compare each queued expectation mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput({e.tag, " stall"},        32'(stall),        32'(e.stall));
      checkOutput({e.tag, " flush"},        32'(flush),        32'(e.flush));
      checkOutput({e.tag, " bubble"},       32'(bubble),       32'(e.bubble));
      checkOutput({e.tag, " flushing"},     32'(flushing),     32'(e.flushing));
      checkOutput({e.tag, " stallTimeout"}, 32'(stallTimeout), 32'(e.timeout));
      checkOutput({e.tag, " stallCycles"},  stallCycles,       e.cycles);
    end
  end

  initial begin
    logic [SC-1:0] one;
    logic [SC-1:0] sR;
    logic [SC-1:0] fR;
    one          = 6'd1;
    rst          = 1'b0;
    stallReq     = '0;
    flushReq     = '0;
    counterClear = 1'b0;

    // Reset: outputs are a pure function of inputs.
    applyStimulus(6'b001000, 6'b000000, 1'b0, 1'b0, "reset0");
    applyStimulus(6'b000001, 6'b100000, 1'b0, 1'b0, "reset1");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "idle");

    // Single stall in stage 3.
    applyStimulus(6'b001000, 6'b000000, 1'b0, 1'b1, "stall3");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "idle");

    // Overlapping flush requests merge and restart the hold.
    applyStimulus(6'b000000, 6'b000100, 1'b0, 1'b1, "flushT0");
    applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, "flushT1");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "flushT2");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "flushT3");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "flushT4");

    // Flush beats stall in the same stage.
    applyStimulus(6'b000001, 6'b010000, 1'b0, 1'b1, "flushPrio0");
    repeat (3) applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "flushPrioN");

    // Watchdog: long stall, release, then clear.
    repeat (6) applyStimulus(6'b100000, 6'b000000, 1'b0, 1'b1, "wdStall");
    repeat (2) applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "wdRelease");
    applyStimulus(6'b100000, 6'b000000, 1'b1, 1'b1, "wdClear");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "wdAfterClear");

    // Reset in the middle of a flush hold aborts it without a clock edge.
    applyStimulus(6'b000000, 6'b010000, 1'b0, 1'b1, "midFlushReq");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "midFlushHeld");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b0, "midFlushReset");
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1, "postReset");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      sR = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      fR = '0;
      if ($urandom_range(0, 5) == 0) fR = one << $urandom_range(0, SC - 1);
      if ($urandom_range(0, 15) == 0) fR = fR | (one << $urandom_range(0, SC - 1));
      applyStimulus(sR, fR, ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 99) != 0), "random");
    end

    repeat (5) begin
      if (expQ.size() > 0) @(negedge clk);
    end
    @(negedge clk);
    if (expQ.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_controller.md
PIPELINE_STAGE_CONTROLLER -- requirements
Module: pipeline_stage_controller

Interface
REQ-001 SHALL have parameter STAGE_COUNT, default 6, number of pipeline stages (stage 0 oldest-fetch/youngest-instruction, stage STAGE_COUNT-1 last, oldest instruction); legal range 2..16.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, total cycles a flush is held asserted; legal range 1..15.
REQ-003 SHALL have parameter STALL_TIMEOUT, default 255, consecutive-stall cycles before watchdog fires; legal range 1..65535.
REQ-004 Ports, one per line: name direction width meaning:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- stallReq  input  STAGE_COUNT  per-stage "cannot advance" request
- flushReq  input  STAGE_COUNT  per-stage redirect request; bit k flushes all stages younger than k
- counterClear  input  1  synchronous clear of stallCycles and stallTimeout
- stall  output  STAGE_COUNT  per-stage hold-register enable inverse
- flush  output  STAGE_COUNT  per-stage invalidate
- bubble  output  STAGE_COUNT  insert NOP into stage i; bit 0 always 0
- flushing  output  1  FSM in FLUSH state
- stallTimeout  output  1  sticky watchdog flag
- stallCycles  output  32  saturating count of cycles with any stall bit set

Function
REQ-005 Flush mask from request: reqMask[i]=1 iff some flushReq[k]=1 with k>i; simultaneous requests merge (OR), so highest k dominates; flushReq[0] contributes nothing.
REQ-006 flush SHALL equal reqMask OR heldMask, combinationally, so the first flush cycle has zero latency.
REQ-007 FSM states RUN and FLUSH; RUN->FLUSH when reqMask!=0 and FLUSH_CYCLES>1; FLUSH->RUN when hold counter reaches 0 and reqMask==0; FLUSH_CYCLES==1 SHALL never enter FLUSH.
REQ-008 On RUN->FLUSH: heldMask<=reqMask, holdCount<=FLUSH_CYCLES-2; in FLUSH each cycle holdCount decrements; heldMask SHALL be zero in RUN.
REQ-009 New reqMask!=0 while in FLUSH: heldMask<=heldMask|reqMask, holdCount<=FLUSH_CYCLES-2 (restart); state stays FLUSH.
REQ-010 Stall propagation: rawStall[i]=OR of stallReq[j] for j>=i (older stage stall freezes all younger stages).
REQ-011 stall[i]=rawStall[i] AND NOT flush[i]; flush has priority over stall in the same stage.
REQ-012 bubble[i], i>=1: stall[i-1] AND NOT stall[i] AND NOT flush[i]; bubble[0]=0.
REQ-013 Watchdog counter increments each cycle with |stall, clears to 0 on a cycle with stall==0; saturates at STALL_TIMEOUT; stallTimeout sets when counter reaches STALL_TIMEOUT and stays set until counterClear or reset.
REQ-014 stallCycles increments by 1 each cycle with |stall, saturates at 0xFFFFFFFF, never wraps.
REQ-015 counterClear same cycle as a stall: clear wins; counters read 0 next cycle.
REQ-016 flushing output SHALL be registered state (1 iff FSM==FLUSH).

Reset
REQ-017 On rst low, asynchronously: FSM=RUN, heldMask=0, holdCount=0, watchdog=0, stallTimeout=0, stallCycles=0.
REQ-018 During reset, stall/flush/bubble SHALL follow REQ-006/010-012 with heldMask=0 (pure function of inputs); reset mid-FLUSH aborts the flush hold immediately.

Structure
REQ-019 FSM state enum and FLUSH_CYCLES/STALL_TIMEOUT defaults SHALL live in RafiTypes package.
REQ-020 Watchdog+stallCycles logic SHALL be one sub-module, stall_watchdog, parameterised by STALL_TIMEOUT; rest is in the top.

Verification
REQ-021 STAGE_COUNT=6, stallReq=6'b001000 one cycle -> stall=6'b001111, bubble=6'b010000, flush=0.
REQ-022 FLUSH_CYCLES=2, flushReq=6'b010000 one cycle with stallReq=6'b000001 -> cycle0 flush=6'b001111, stall=0; cycle1 flush=6'b001111, flushing=1; cycle2 flush=0, flushing=0.
REQ-023 FLUSH_CYCLES=3, flushReq=6'b000100 at t0 and 6'b100000 at t1 -> flush=6'b000011 at t0, 6'b011111 at t1..t3, 0 at t4.
REQ-024 STALL_TIMEOUT=4, stallReq[5]=1 held 6 cycles -> stallTimeout rises after 4th stall cycle, stays 1 after release; counterClear -> 0, stallCycles=0 next cycle.
REQ-025 rst driven low while flushing=1 -> flushing=0 and heldMask=0 immediately, without clock edge.
